// File: rtl/spi_master_multimode_if.sv
// Bus bundle for spi_master_multimode: local controller handshake plus the
// four-wire SPI side.
//
// Modports:
//   master - the SPI master block: takes start/tx_data/mode bits/cs_sel/miso,
//            drives busy/done/rx_data/sclk/mosi/cs_n/state_dbg.
//   slave  - the opposite view, for whatever sits around the master
//            (local controller together with the SPI slave side).
//
// Handshake (start/busy/done): start is taken only on a rising clk edge where
// the master is idle (busy=0); the accepting edge latches tx_data, cpol, cpha,
// lsb_first and cs_sel, and busy is high from the next cycle.  A start seen
// while busy=1 is dropped, not queued.  done is a single-cycle pulse with
// busy=0 and rx_data valid; a start held high in that cycle begins the next
// transfer immediately.
interface spi_master_multimode_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CS     = 1
);
    localparam int CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

    logic                  start;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  cpol;
    logic                  cpha;
    logic                  lsb_first;
    logic [CS_W-1:0]       cs_sel;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  sclk;
    logic                  mosi;
    logic                  miso;
    logic [NUM_CS-1:0]     cs_n;
    logic [1:0]            state_dbg;

    modport master (
        input  start, tx_data, cpol, cpha, lsb_first, cs_sel, miso,
        output busy, done, rx_data, sclk, mosi, cs_n, state_dbg
    );

    modport slave (
        output start, tx_data, cpol, cpha, lsb_first, cs_sel, miso,
        input  busy, done, rx_data, sclk, mosi, cs_n, state_dbg
    );
endinterface

// File: rtl/spi_master_multimode.sv
// SPI master with runtime CPOL/CPHA (modes 0-3), MSB/LSB-first ordering,
// a fixed SCLK divider and NUM_CS chip selects.
//
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous, active-low
//   bus   - spi_master_multimode_if.master (handshake, mode bits, SPI pins,
//           FSM state for debug)
//
// Timing: a transfer is SETUP (CLK_DIV cycles, sclk idle), XFER
// (2*DATA_WIDTH half-periods of CLK_DIV cycles each) and HOLD (CLK_DIV
// cycles, sclk idle, chip select still low); done follows in the next cycle.
// SCLK edge k is launched at the clock edge that begins half-period k, so
// the first SCLK edge comes CLK_DIV cycles after chip select falls.
module spi_master_multimode #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CS     = 1,
    parameter int CLK_DIV    = 2
) (
    input logic                    clk,
    input logic                    reset,
    spi_master_multimode_if.master bus
);
    localparam int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EDGE_W = $clog2(2 * DATA_WIDTH);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [DIV_W-1:0]      div_cnt;
    logic [EDGE_W-1:0]     edge_cnt;   // half-period currently running in XFER
    logic [DATA_WIDTH-1:0] tx_sh;      // bits still to be put on mosi
    logic [DATA_WIDTH-1:0] rx_sh;
    logic                  cpol_q, cpha_q, lsb_q;
    logic                  busy_q, done_q, sclk_q, mosi_q;
    logic [DATA_WIDTH-1:0] rx_q;
    logic [NUM_CS-1:0]     cs_n_q;
    logic [NUM_CS-1:0]     cs_dec;

    logic                  div_last, edge_last;
    logic                  accept, edge_go, lead, do_sample, do_drive;
    logic [EDGE_W-1:0]     edge_idx;   // index of the SCLK edge fired this cycle

    assign div_last  = (div_cnt == DIV_LAST);
    assign edge_last = (edge_cnt == EDGE_LAST);

    // Out-of-range cs_sel matches no line, so the transfer runs deselected.
    always_comb begin
        cs_dec = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (bus.cs_sel == CS_W'(i)) cs_dec[i] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        edge_go   = 1'b0;
        edge_idx  = '0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SETUP;
                    accept  = 1'b1;
                end
            end
            SETUP: begin
                if (div_last) begin
                    state_d = XFER;
                    edge_go = 1'b1;
                end
            end
            XFER: begin
                if (div_last) begin
                    if (edge_last) begin
                        state_d = HOLD;
                    end else begin
                        edge_go  = 1'b1;
                        edge_idx = edge_cnt + EDGE_W'(1);
                    end
                end
            end
            HOLD: begin
                if (div_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Even edges are leading. CPHA=0 samples on leading and shifts on
        // trailing (skipping the final trailing edge); CPHA=1 the reverse.
        lead      = ~edge_idx[0];
        do_sample = edge_go & (lead ^ cpha_q);
        do_drive  = edge_go & ~(lead ^ cpha_q) & (edge_idx != EDGE_LAST);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt  <= '0;
            edge_cnt <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            lsb_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            rx_q     <= '0;
            cs_n_q   <= '1;
        end else begin
            done_q <= 1'b0;

            if (state_q == IDLE || div_last) div_cnt <= '0;
            else                             div_cnt <= div_cnt + DIV_W'(1);

            if (accept) begin
                cpol_q   <= bus.cpol;
                cpha_q   <= bus.cpha;
                lsb_q    <= bus.lsb_first;
                busy_q   <= 1'b1;
                sclk_q   <= bus.cpol;
                cs_n_q   <= cs_dec;
                rx_sh    <= '0;
                edge_cnt <= '0;
                // CPHA=0 needs the first bit valid before the first edge,
                // so it goes out at accept; CPHA=1 drives it on edge 0.
                if (!bus.cpha) begin
                    mosi_q <= bus.lsb_first ? bus.tx_data[0] : bus.tx_data[DATA_WIDTH-1];
                    tx_sh  <= bus.lsb_first ? (bus.tx_data >> 1) : (bus.tx_data << 1);
                end else begin
                    tx_sh  <= bus.tx_data;
                end
            end

            if (edge_go) begin
                sclk_q   <= ~sclk_q;
                edge_cnt <= edge_idx;
            end

            if (do_drive) begin
                mosi_q <= lsb_q ? tx_sh[0] : tx_sh[DATA_WIDTH-1];
                tx_sh  <= lsb_q ? (tx_sh >> 1) : (tx_sh << 1);
            end

            if (do_sample) begin
                rx_sh <= lsb_q ? {bus.miso, rx_sh[DATA_WIDTH-1:1]}
                               : {rx_sh[DATA_WIDTH-2:0], bus.miso};
            end

            // An even number of edges already leaves sclk at cpol; pinning it
            // here keeps the idle level explicit through HOLD.
            if (state_q == HOLD) sclk_q <= cpol_q;

            if (state_q == HOLD && div_last) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
                cs_n_q <= '1;
                rx_q   <= rx_sh;
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.rx_data   = rx_q;
    assign bus.sclk      = sclk_q;
    assign bus.mosi      = mosi_q;
    assign bus.cs_n      = cs_n_q;
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_spi_master_multimode.sv
// Directed bench for spi_master_multimode: three instances (8b/1cs/div2,
// 16b/4cs/div1, 8b/3cs/div1), loopback and a behavioural mode-aware slave.
module tb_spi_master_multimode;
    localparam int NEVER = 1000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [15:0] exp_q[$];

    spi_master_multimode_if #(.DATA_WIDTH(8),  .NUM_CS(1)) bus0();
    spi_master_multimode_if #(.DATA_WIDTH(16), .NUM_CS(4)) bus1();
    spi_master_multimode_if #(.DATA_WIDTH(8),  .NUM_CS(3)) bus2();

    spi_master_multimode #(.DATA_WIDTH(8),  .NUM_CS(1), .CLK_DIV(2)) u0 (.clk(clk), .reset(rst_n), .bus(bus0));
    spi_master_multimode #(.DATA_WIDTH(16), .NUM_CS(4), .CLK_DIV(1)) u1 (.clk(clk), .reset(rst_n), .bus(bus1));
    spi_master_multimode #(.DATA_WIDTH(8),  .NUM_CS(3), .CLK_DIV(1)) u2 (.clk(clk), .reset(rst_n), .bus(bus2));

    logic loopback = 1'b1;
    logic s_miso   = 1'b0;
    assign bus0.miso = loopback ? bus0.mosi : s_miso;
    assign bus1.miso = bus1.mosi;
    assign bus2.miso = bus2.mosi;

    // ---------------- behavioural slave on bus0 ----------------
    logic       s_cpol = 1'b0, s_cpha = 1'b0, s_lsb = 1'b0;
    logic [7:0] s_tx = 8'h00, s_sh = 8'h00, s_rx = 8'h00;
    logic       s_prev_csn = 1'b1, s_prev_sclk = 1'b0;

    always @(negedge clk) begin
        if (!bus0.cs_n[0] && s_prev_csn) begin
            s_sh = s_tx;
            s_rx = 8'h00;
            if (!s_cpha) begin
                s_miso = s_lsb ? s_sh[0] : s_sh[7];
                s_sh   = s_lsb ? (s_sh >> 1) : (s_sh << 1);
            end
        end else if (!bus0.cs_n[0] && !s_prev_csn && (bus0.sclk !== s_prev_sclk)) begin
            if ((s_prev_sclk == s_cpol) ^ s_cpha) begin
                s_rx = s_lsb ? {bus0.mosi, s_rx[7:1]} : {s_rx[6:0], bus0.mosi};
            end else begin
                s_miso = s_lsb ? s_sh[0] : s_sh[7];
                s_sh   = s_lsb ? (s_sh >> 1) : (s_sh << 1);
            end
        end
        s_prev_csn  = bus0.cs_n[0];
        s_prev_sclk = bus0.sclk;
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver / monitor for bus0 ----------------
    int         r_done_k, r_edges, r_e1_k, r_e3_k;
    logic [3:0] r_k1_csn;
    logic       r_k1_busy, r_k1_sclk, r_k1_mosi;
    logic       r_done_busy, r_done_sclk, r_after_done, r_after_busy;
    logic [3:0] r_done_csn;
    logic       rs_csn, rs_sclk, rs_busy;
    logic [7:0] rs_rx;
    logic [1:0] rs_state;
    logic [2:0] r_csn_and;

    task automatic run0(input logic [7:0] tx, input logic pol, input logic pha,
                        input logic lsb, input logic sel, input logic hold,
                        input int inj_k, input int rst_k);
        int   k;
        logic prev;
        @(negedge clk);
        bus0.tx_data   = tx;
        bus0.cpol      = pol;
        bus0.cpha      = pha;
        bus0.lsb_first = lsb;
        bus0.cs_sel    = sel;
        bus0.start     = 1'b1;
        k = 0; r_done_k = 0; r_edges = 0; r_e1_k = 0; r_e3_k = 0; prev = pol;
        while (r_done_k == 0 && k < 80) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                r_k1_csn  = {3'b000, bus0.cs_n};
                r_k1_busy = bus0.busy;
                r_k1_sclk = bus0.sclk;
                r_k1_mosi = bus0.mosi;
                prev      = bus0.sclk;
                if (!hold) begin
                    bus0.start     = 1'b0;
                    bus0.cpol      = ~pol;
                    bus0.cpha      = ~pha;
                    bus0.lsb_first = ~lsb;
                end
            end else if (bus0.sclk !== prev) begin
                r_edges++;
                if (r_edges == 1) r_e1_k = k;
                if (r_edges == 3) r_e3_k = k;
                prev = bus0.sclk;
            end
            if (k == inj_k) begin
                bus0.start   = 1'b1;
                bus0.tx_data = 8'hFF;
            end
            if (k == inj_k + 1) bus0.start = 1'b0;
            if (k == rst_k) begin
                rst_n = 1'b0;
                #1;
                rs_csn   = bus0.cs_n[0];
                rs_sclk  = bus0.sclk;
                rs_busy  = bus0.busy;
                rs_rx    = bus0.rx_data;
                rs_state = bus0.state_dbg;
            end
            if (k == rst_k + 2) rst_n = 1'b1;
            if (bus0.done === 1'b1) begin
                r_done_k    = k;
                r_done_busy = bus0.busy;
                r_done_sclk = bus0.sclk;
                r_done_csn  = {3'b000, bus0.cs_n};
            end
        end
        @(negedge clk);
        r_after_done = bus0.done;
        r_after_busy = bus0.busy;
        bus0.start   = 1'b0;
    endtask

    task automatic run1(input logic [15:0] tx, input logic [1:0] sel);
        int k;
        @(negedge clk);
        bus1.tx_data = tx;
        bus1.cs_sel  = sel;
        bus1.start   = 1'b1;
        k = 0; r_done_k = 0;
        while (r_done_k == 0 && k < 80) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                bus1.start = 1'b0;
                r_k1_csn   = bus1.cs_n;
            end
            if (bus1.done === 1'b1) r_done_k = k;
        end
    endtask

    task automatic run2(input logic [7:0] tx, input logic [1:0] sel);
        int k;
        @(negedge clk);
        bus2.tx_data = tx;
        bus2.cs_sel  = sel;
        bus2.start   = 1'b1;
        k = 0; r_done_k = 0; r_csn_and = 3'b111;
        while (r_done_k == 0 && k < 80) begin
            @(negedge clk);
            k++;
            if (k == 1) bus2.start = 1'b0;
            r_csn_and = r_csn_and & bus2.cs_n;
            if (bus2.done === 1'b1) r_done_k = k;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int k2;
        bus0.start = 1'b0; bus0.tx_data = '0; bus0.cpol = 1'b0; bus0.cpha = 1'b0;
        bus0.lsb_first = 1'b0; bus0.cs_sel = '0;
        bus1.start = 1'b0; bus1.tx_data = '0; bus1.cpol = 1'b0; bus1.cpha = 1'b0;
        bus1.lsb_first = 1'b0; bus1.cs_sel = '0;
        bus2.start = 1'b0; bus2.tx_data = '0; bus2.cpol = 1'b0; bus2.cpha = 1'b0;
        bus2.lsb_first = 1'b0; bus2.cs_sel = '0;

        // Reset values
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy",  32'(bus0.busy),      32'd0);
        check("rst_done",  32'(bus0.done),      32'd0);
        check("rst_rx",    32'(bus0.rx_data),   32'h00);
        check("rst_sclk",  32'(bus0.sclk),      32'd0);
        check("rst_mosi",  32'(bus0.mosi),      32'd0);
        check("rst_csn",   32'(bus0.cs_n),      32'h1);
        check("rst_state", 32'(bus0.state_dbg), 32'd0);
        check("rst_csn1",  32'(bus1.cs_n),      32'hF);
        rst_n = 1'b1;

        // Mode 0, MSB first, loopback 0xA5
        exp_q.push_back(16'h00A5);
        run0(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NEVER, NEVER);
        check("m0_csn_k1",   32'(r_k1_csn),     32'h0);
        check("m0_busy_k1",  32'(r_k1_busy),    32'd1);
        check("m0_sclk_k1",  32'(r_k1_sclk),    32'd0);
        check("m0_edges",    32'(r_edges),      32'd16);
        check("m0_edge1_k",  32'(r_e1_k),       32'd3);
        check("m0_period",   32'(r_e3_k - r_e1_k), 32'd4);
        check("m0_done_k",   32'(r_done_k),     32'd37);
        check("m0_rx",       32'(bus0.rx_data), 32'(exp_q.pop_front()));
        check("m0_done_busy", 32'(r_done_busy), 32'd0);
        check("m0_done_csn", 32'(r_done_csn),   32'h1);
        check("m0_done_1cyc", 32'(r_after_done), 32'd0);
        check("m0_idle_busy", 32'(r_after_busy), 32'd0);

        // Modes 1..3 against the slave: master 0xC3 out, slave 0x3C back
        loopback = 1'b0;
        for (int m = 1; m < 4; m++) begin
            s_cpol = m[1]; s_cpha = m[0]; s_lsb = 1'b0; s_tx = 8'h3C;
            exp_q.push_back(16'h003C);
            run0(8'hC3, m[1], m[0], 1'b0, 1'b0, 1'b0, NEVER, NEVER);
            check($sformatf("mode%0d_rx", m),        32'(bus0.rx_data), 32'(exp_q.pop_front()));
            check($sformatf("mode%0d_slave_rx", m),  32'(s_rx),         32'hC3);
            check($sformatf("mode%0d_sclk_k1", m),   32'(r_k1_sclk),    32'(m[1]));
            check($sformatf("mode%0d_sclk_done", m), 32'(r_done_sclk),  32'(m[1]));
            check($sformatf("mode%0d_edges", m),     32'(r_edges),      32'd16);
            check($sformatf("mode%0d_done_k", m),    32'(r_done_k),     32'd37);
        end

        // LSB first, loopback 0x01
        loopback = 1'b1;
        run0(8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, NEVER, NEVER);
        check("lsb_first_mosi", 32'(r_k1_mosi),    32'd1);
        check("lsb_loop_rx",    32'(bus0.rx_data), 32'h01);

        // MSB-first slave sends 0x80 to an LSB-first master
        loopback = 1'b0;
        s_cpol = 1'b0; s_cpha = 1'b0; s_lsb = 1'b0; s_tx = 8'h80;
        run0(8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, NEVER, NEVER);
        check("lsb_slave_rx",    32'(bus0.rx_data), 32'h01);
        check("lsb_slave_sees",  32'(s_rx),         32'h80);

        // Start pulsed while busy with 0xFF: ignored
        loopback = 1'b1;
        exp_q.push_back(16'h003C);
        run0(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8, NEVER);
        check("busy_start_rx",     32'(bus0.rx_data), 32'(exp_q.pop_front()));
        check("busy_start_done_k", 32'(r_done_k),     32'd37);

        // Start held through done: back-to-back transfer
        run0(8'h96, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, NEVER, NEVER);
        check("b2b_done_k",    32'(r_done_k),     32'd37);
        check("b2b_rx1",       32'(bus0.rx_data), 32'h96);
        check("b2b_next_busy", 32'(r_after_busy), 32'd1);
        k2 = 1;
        while (bus0.done !== 1'b1 && k2 < 80) begin
            @(negedge clk);
            k2++;
        end
        check("b2b_done2_k", 32'(k2),           32'd37);
        check("b2b_rx2",     32'(bus0.rx_data), 32'h96);

        // Reset at cycle N+10 of a mode-2 transfer
        run0(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, NEVER, 10);
        check("mid_rst_csn",   32'(rs_csn),   32'd1);
        check("mid_rst_sclk",  32'(rs_sclk),  32'd0);
        check("mid_rst_busy",  32'(rs_busy),  32'd0);
        check("mid_rst_rx",    32'(rs_rx),    32'h00);
        check("mid_rst_state", 32'(rs_state), 32'd0);
        check("mid_rst_nodone", 32'(r_done_k), 32'd0);

        exp_q.push_back(16'h0069);
        run0(8'h69, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NEVER, NEVER);
        check("post_rst_rx",     32'(bus0.rx_data), 32'(exp_q.pop_front()));
        check("post_rst_done_k", 32'(r_done_k),     32'd37);

        // 16-bit, 4 chip selects, CLK_DIV=1
        run1(16'hBEEF, 2'd2);
        check("w16_csn_sel2", 32'(r_k1_csn),     32'hB);
        check("w16_done_k",   32'(r_done_k),     32'd35);
        check("w16_rx",       32'(bus1.rx_data), 32'hBEEF);
        run1(16'h1234, 2'd3);
        check("w16_csn_sel3", 32'(r_k1_csn),     32'h7);
        check("w16_rx2",      32'(bus1.rx_data), 32'h1234);

        // NUM_CS=3: cs_sel=3 selects nothing, transfer still runs
        run2(8'hA7, 2'd3);
        check("cs3_none_low", 32'(r_csn_and),    32'h7);
        check("cs3_done_k",   32'(r_done_k),     32'd19);
        check("cs3_rx",       32'(bus2.rx_data), 32'hA7);
        run2(8'h5C, 2'd1);
        check("cs3_sel1_low", 32'(r_csn_and),    32'h5);
        check("cs3_rx2",      32'(bus2.rx_data), 32'h5C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
